// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU control path.
//  - Default widths and memory timeout.
//  - Opcode encodings (upper nibble of the instruction word).
//  - Sequencer state encoding.
package cpu_pkg;

   localparam int unsigned CPU_ADDR_W      = 4;
   localparam int unsigned CPU_DATA_W      = 8;
   localparam int unsigned CPU_OP_W        = 4;
   localparam int unsigned CPU_MEM_TIMEOUT = 15;

   localparam logic [CPU_OP_W-1:0] OP_JMP = 4'h0;
   localparam logic [CPU_OP_W-1:0] OP_ADD = 4'h1;
   localparam logic [CPU_OP_W-1:0] OP_SUB = 4'h2;
   localparam logic [CPU_OP_W-1:0] OP_LDA = 4'h3;
   localparam logic [CPU_OP_W-1:0] OP_STA = 4'h4;
   localparam logic [CPU_OP_W-1:0] OP_AND = 4'h5;
   localparam logic [CPU_OP_W-1:0] OP_OR  = 4'h6;
   localparam logic [CPU_OP_W-1:0] OP_NOT = 4'h7;
   localparam logic [CPU_OP_W-1:0] OP_XOR = 4'h8;
   localparam logic [CPU_OP_W-1:0] OP_JZ  = 4'h9;
   localparam logic [CPU_OP_W-1:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_MEM    = 3'd3,
      ST_EXEC   = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

endpackage

// File: rtl/cpu_control_unit_program_counter.sv
// Program counter: load / increment / hold, wrapping naturally at 2^ADDR_W.
//  clk, rst_n   : clock, async active-low reset (PC -> 0)
//  load_i       : take load_val_i verbatim (has priority over inc_i)
//  inc_i        : PC + 1 with wrap
//  load_val_i   : jump target
//  pc_o         : current PC
module program_counter #(
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              inc_i,
   input  logic [ADDR_W-1:0] load_val_i,
   output logic [ADDR_W-1:0] pc_o
);

   logic [ADDR_W-1:0] pc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= '0;
      end else if (load_i) begin
         pc_q <= load_val_i;
      end else if (inc_i) begin
         pc_q <= pc_q + ADDR_W'(1);
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
//  clk, resetN          : clock, async active-low reset
//  start                : leave IDLE/HALT (ignored while running)
//  romAddress/romData   : instruction fetch (address = PC)
//  memReq/memWe/memAddress/memAck : data-memory handshake
//  aluOp/accLoad        : one-cycle accumulator write strobe + opcode
//  accZero              : accumulator-is-zero flag for JZ
//  busy/halted/fault    : status; fault is sticky until the next start
// All outputs are decoded from registered state/IR/PC only.
module cpu_control_unit
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W      = CPU_ADDR_W,
   parameter int unsigned DATA_W      = CPU_DATA_W,
   parameter int unsigned MEM_TIMEOUT = CPU_MEM_TIMEOUT
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              start,
   output logic [ADDR_W-1:0] romAddress,
   input  logic [DATA_W-1:0] romData,
   output logic              memReq,
   output logic              memWe,
   output logic [ADDR_W-1:0] memAddress,
   input  logic              memAck,
   output logic [3:0]        aluOp,
   output logic              accLoad,
   input  logic              accZero,
   output logic              busy,
   output logic              halted,
   output logic              fault
);

   localparam int unsigned OP_W  = DATA_W - ADDR_W;
   localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              fault_q, fault_d;
   logic              pc_load, pc_inc;
   logic [ADDR_W-1:0] pc;

   logic [OP_W-1:0]   opcode;
   logic [3:0]        op4;
   logic [ADDR_W-1:0] operand;

   assign opcode  = ir_q[DATA_W-1:ADDR_W];
   assign op4     = 4'(opcode);
   assign operand = ir_q[ADDR_W-1:0];

   program_counter #(.ADDR_W(ADDR_W)) u_pc (
      .clk        (clk),
      .rst_n      (resetN),
      .load_i     (pc_load),
      .inc_i      (pc_inc),
      .load_val_i (operand),
      .pc_o       (pc)
   );

   // State, instruction register, timeout counter, sticky fault
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= ST_IDLE;
         ir_q    <= '0;
         cnt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

   // Next-state, IR/counter/fault update and PC control
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      cnt_d   = cnt_q;
      fault_d = fault_q;
      pc_load = 1'b0;
      pc_inc  = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_HALT: begin
            if (start) begin
               state_d = ST_FETCH;
               fault_d = 1'b0;
            end
         end
         ST_FETCH: begin
            ir_d    = romData;
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            case (op4)
               OP_JMP: begin
                  pc_load = 1'b1;
                  state_d = ST_FETCH;
               end
               OP_JZ: begin
                  pc_load = accZero;
                  pc_inc  = !accZero;
                  state_d = ST_FETCH;
               end
               OP_HLT: state_d = ST_HALT;
               OP_NOT: state_d = ST_EXEC;
               OP_ADD, OP_SUB, OP_LDA, OP_STA, OP_AND, OP_OR, OP_XOR: begin
                  cnt_d   = '0;
                  state_d = ST_MEM;
               end
               default: begin
                  pc_inc  = 1'b1;
                  state_d = ST_FETCH;
               end
            endcase
         end
         ST_MEM: begin
            if (memAck) begin
               cnt_d = '0;
               if (op4 == OP_STA) begin
                  pc_inc  = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_EXEC;
               end
            end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
               // Last permitted wait cycle without an ack: give up
               cnt_d   = '0;
               fault_d = 1'b1;
               state_d = ST_HALT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_EXEC: begin
            pc_inc  = 1'b1;
            state_d = ST_FETCH;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Moore output decode
   always_comb begin
      romAddress = pc;
      memReq     = 1'b0;
      memWe      = 1'b0;
      memAddress = '0;
      aluOp      = 4'h0;
      accLoad    = 1'b0;
      busy       = 1'b1;
      halted     = 1'b0;
      fault      = fault_q;

      unique case (state_q)
         ST_IDLE: busy = 1'b0;
         ST_HALT: begin
            busy   = 1'b0;
            halted = 1'b1;
         end
         ST_MEM: begin
            memReq     = 1'b1;
            memWe      = (op4 == OP_STA);
            memAddress = operand;
         end
         ST_EXEC: begin
            accLoad = 1'b1;
            aluOp   = op4;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed, table-driven bench for cpu_control_unit with a behavioural ROM.
module tb_cpu_control_unit;

   logic       clk;
   logic       resetN;
   logic       start;
   logic [3:0] romAddress;
   logic [7:0] romData;
   logic       memReq;
   logic       memWe;
   logic [3:0] memAddress;
   logic       memAck;
   logic [3:0] aluOp;
   logic       accLoad;
   logic       accZero;
   logic       busy;
   logic       halted;
   logic       fault;

   logic [7:0] rom [16];

   int tests_run;
   int tests_failed;

   typedef struct packed {
      logic       busy;
      logic       halted;
      logic       fault;
      logic       req;
      logic       we;
      logic       load;
      logic [3:0] rom_a;
      logic [3:0] mem_a;
      logic [3:0] alu;
   } obs_t;

   typedef struct {
      logic start;
      logic ack;
      logic az;
      obs_t exp;
   } vec_t;

   localparam int NVEC = 28;
   vec_t vecs [NVEC];

   cpu_control_unit dut (
      .clk        (clk),
      .resetN     (resetN),
      .start      (start),
      .romAddress (romAddress),
      .romData    (romData),
      .memReq     (memReq),
      .memWe      (memWe),
      .memAddress (memAddress),
      .memAck     (memAck),
      .aluOp      (aluOp),
      .accLoad    (accLoad),
      .accZero    (accZero),
      .busy       (busy),
      .halted     (halted),
      .fault      (fault)
   );

   assign romData = rom[romAddress];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t o(input logic b, input logic h, input logic f,
                              input logic rq, input logic we, input logic ld,
                              input logic [3:0] ra, input logic [3:0] ma,
                              input logic [3:0] alu);
      obs_t r;
      r.busy = b; r.halted = h; r.fault = f; r.req = rq; r.we = we;
      r.load = ld; r.rom_a = ra; r.mem_a = ma; r.alu = alu;
      return r;
   endfunction

   // Plain running state (FETCH/DECODE) at a given PC
   function automatic obs_t run(input logic [3:0] ra);
      return o(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ra, 4'h0, 4'h0);
   endfunction

   function automatic vec_t v(input logic s, input logic a, input logic z, input obs_t e);
      vec_t r;
      r.start = s; r.ack = a; r.az = z; r.exp = e;
      return r;
   endfunction

   task automatic check(input string name, input obs_t exp);
      obs_t act;
      act = {busy, halted, fault, memReq, memWe, accLoad, romAddress, memAddress, aluOp};
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got busy=%b halted=%b fault=%b req=%b we=%b load=%b romA=%h memA=%h alu=%h, expected busy=%b halted=%b fault=%b req=%b we=%b load=%b romA=%h memA=%h alu=%h",
                  name, act.busy, act.halted, act.fault, act.req, act.we, act.load,
                  act.rom_a, act.mem_a, act.alu, exp.busy, exp.halted, exp.fault,
                  exp.req, exp.we, exp.load, exp.rom_a, exp.mem_a, exp.alu);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      obs_t zero_o;
      obs_t idle_o;
      obs_t add_mem;
      obs_t halt_o;

      tests_run    = 0;
      tests_failed = 0;
      zero_o  = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
      idle_o  = zero_o;
      add_mem = o(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h2, 4'h0);
      halt_o  = o(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);

      for (int i = 0; i < 16; i++) rom[i] = 8'hF0;
      rom[4'h0] = 8'h31; // LDA 1
      rom[4'h1] = 8'h93; // JZ 3 (taken)
      rom[4'h3] = 8'h95; // JZ 5 (not taken)
      rom[4'h4] = 8'h0C; // JMP C
      rom[4'hC] = 8'hA0; // NOP
      rom[4'hD] = 8'h05; // JMP 5
      rom[4'h5] = 8'h4A; // STA A
      rom[4'h6] = 8'h0F; // JMP F
      rom[4'hF] = 8'h70; // NOT

      vecs[0]  = v(1, 0, 0, run(4'h0));                              // IDLE -> FETCH
      vecs[1]  = v(0, 0, 0, run(4'h0));                              // DECODE LDA 1
      vecs[2]  = v(0, 0, 0, o(1, 0, 0, 1, 0, 0, 4'h0, 4'h1, 4'h0));  // MEM read
      vecs[3]  = v(0, 1, 0, o(1, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h3));  // EXEC LDA
      vecs[4]  = v(0, 0, 0, run(4'h1));                              // FETCH @1
      vecs[5]  = v(0, 0, 0, run(4'h1));                              // DECODE JZ 3
      vecs[6]  = v(0, 0, 1, run(4'h3));                              // taken
      vecs[7]  = v(1, 0, 0, run(4'h3));                              // start ignored
      vecs[8]  = v(0, 0, 0, run(4'h4));                              // JZ not taken
      vecs[9]  = v(0, 0, 0, run(4'h4));                              // DECODE JMP C
      vecs[10] = v(0, 0, 0, run(4'hC));
      vecs[11] = v(0, 0, 0, run(4'hC));                              // DECODE NOP
      vecs[12] = v(0, 0, 0, run(4'hD));
      vecs[13] = v(0, 0, 0, run(4'hD));                              // DECODE JMP 5
      vecs[14] = v(0, 0, 0, run(4'h5));
      vecs[15] = v(0, 1, 0, run(4'h5));                              // ack outside MEM
      vecs[16] = v(0, 0, 0, o(1, 0, 0, 1, 1, 0, 4'h5, 4'hA, 4'h0));  // STA MEM #1
      vecs[17] = v(0, 0, 0, o(1, 0, 0, 1, 1, 0, 4'h5, 4'hA, 4'h0));  // wait 1
      vecs[18] = v(0, 0, 0, o(1, 0, 0, 1, 1, 0, 4'h5, 4'hA, 4'h0));  // wait 2
      vecs[19] = v(0, 0, 0, o(1, 0, 0, 1, 1, 0, 4'h5, 4'hA, 4'h0));  // wait 3
      vecs[20] = v(0, 1, 0, run(4'h6));                              // ack -> PC+1
      vecs[21] = v(0, 0, 0, run(4'h6));                              // DECODE JMP F
      vecs[22] = v(0, 0, 0, run(4'hF));
      vecs[23] = v(0, 0, 0, run(4'hF));                              // DECODE NOT
      vecs[24] = v(0, 0, 0, o(1, 0, 0, 0, 0, 1, 4'hF, 4'h0, 4'h7));  // EXEC NOT
      vecs[25] = v(0, 0, 0, run(4'h0));                              // PC wrap
      vecs[26] = v(0, 0, 0, run(4'h0));                              // DECODE LDA 1
      vecs[27] = v(0, 0, 0, o(1, 0, 0, 1, 0, 0, 4'h0, 4'h1, 4'h0));  // MEM pending

      resetN  = 1'b0;
      start   = 1'b0;
      memAck  = 1'b0;
      accZero = 1'b0;
      #12;
      check("reset_state", zero_o);
      resetN = 1'b1;
      step();
      check("idle_hold", idle_o);

      for (int i = 0; i < NVEC; i++) begin
         start   = vecs[i].start;
         memAck  = vecs[i].ack;
         accZero = vecs[i].az;
         step();
         check($sformatf("vec%0d", i), vecs[i].exp);
      end
      start   = 1'b0;
      memAck  = 1'b0;
      accZero = 1'b0;

      // Reset while memReq is high must drop it without a clock edge
      #2;
      resetN = 1'b0;
      #1;
      check("rst_async_drop", zero_o);
      step();
      check("rst_held", zero_o);
      resetN = 1'b1;
      step();
      check("rst_release_idle", idle_o);

      // ADD 2 never acked: 15 MEM cycles then HALT with fault
      rom[4'h0] = 8'h12;
      start = 1'b1;
      step();
      check("to_fetch", run(4'h0));
      start = 1'b0;
      step();
      check("to_decode", run(4'h0));
      step();
      check("to_mem1", add_mem);
      for (int i = 2; i <= 15; i++) begin
         step();
         check($sformatf("to_mem%0d", i), add_mem);
      end
      step();
      check("timeout_halt", o(0, 1, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0));
      memAck = 1'b1;
      step();
      check("halt_ignores_ack", o(0, 1, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0));
      memAck = 1'b0;
      start = 1'b1;
      step();
      check("restart_clears_fault", run(4'h0));
      start = 1'b0;

      // HLT at the same PC: hold until start, then refetch there
      rom[4'h0] = 8'hF0;
      step();
      check("hlt_decode", run(4'h0));
      step();
      check("hlt_halt", halt_o);
      step();
      check("hlt_hold1", halt_o);
      step();
      check("hlt_hold2", halt_o);
      start = 1'b1;
      step();
      check("hlt_restart", run(4'h0));
      start = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
